// File: rtl/decode_queue_pkg.sv
// Shared types for the decode stage: opcode classes, ALU ops and the decoded
// bundle stored per instruction-buffer entry.
package decode_queue_pkg;

  localparam int DQ_XLEN      = 64;
  localparam int GPR_IDX_SIZE = 5;

  typedef enum logic [5:0] {
    OP_NOP, OP_LDUR, OP_LDP, OP_STUR, OP_STP, OP_MOVK, OP_MOVZ, OP_ADD,
    OP_ADDS, OP_SUB, OP_SUBS, OP_CMP, OP_MVN, OP_ORR, OP_EOR, OP_ANDS,
    OP_TST, OP_LSL, OP_LSR, OP_UBFM, OP_SBFM, OP_ASR, OP_B, OP_BR,
    OP_B_COND, OP_BL, OP_BLR, OP_CBNZ, OP_CBZ, OP_RET, OP_HLT, OP_ADR,
    OP_ADRP, OP_CSEL, OP_CSINC, OP_CSINV, OP_CSNEG, OP_ERROR
  } opcode_t;

  typedef enum logic [4:0] {
    ALU_OP_PLUS, ALU_OP_MINUS, ALU_OP_INV, ALU_OP_OR, ALU_OP_EOR, ALU_OP_AND,
    ALU_OP_MOV, ALU_OP_CSNEG, ALU_OP_CSINC, ALU_OP_CSINV, ALU_OP_CSEL,
    ALU_OP_LSL, ALU_OP_LSR, ALU_OP_ASR, ALU_OP_PASS_A, ALU_OP_ORN,
    ALU_OP_UBFM, ALU_OP_SBFM
  } alu_op_t;

  typedef struct packed {
    logic valb_sel;
    logic set_CC;
    logic dmem_read;
    logic dmem_write;
    logic wval_sel;
    logic w_enable;
  } d_ctl_bundle_t;

  typedef struct packed {
    opcode_t                 op;
    logic [DQ_XLEN-1:0]      pc;
    logic [DQ_XLEN-1:0]      imm;
    logic [GPR_IDX_SIZE-1:0] src1;
    logic                    src1_v;
    logic [GPR_IDX_SIZE-1:0] src2;
    logic                    src2_v;
    logic [GPR_IDX_SIZE-1:0] dst;
    logic                    dst_v;
    alu_op_t                 alu_op;
    d_ctl_bundle_t           ctl;
  } decoded_insn_t;

  // Register-register forms: second operand comes from insn[20:16].
  function automatic logic reads_rm(input opcode_t op);
    return op inside {OP_ADDS, OP_SUBS, OP_CMP, OP_MVN, OP_ORR, OP_EOR,
                      OP_ANDS, OP_TST, OP_CSEL, OP_CSINC, OP_CSINV, OP_CSNEG};
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and dispatch-side handshakes of the decode queue, plus flush.
interface decode_queue_if import decode_queue_pkg::*; #(
  parameter int XLEN  = DQ_XLEN,
  parameter int DEPTH = 4
) ();

  logic                    in_flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_insnbits;
  opcode_t                 in_op;
  logic [XLEN-1:0]         in_pc;

  logic                    out_valid;
  logic                    out_ready;
  opcode_t                 out_op;
  logic [XLEN-1:0]         out_pc;
  logic [XLEN-1:0]         out_imm;
  logic [GPR_IDX_SIZE-1:0] out_src1;
  logic [GPR_IDX_SIZE-1:0] out_src2;
  logic [GPR_IDX_SIZE-1:0] out_dst;
  logic                    out_src1_v;
  logic                    out_src2_v;
  logic                    out_dst_v;
  alu_op_t                 out_alu_op;
  d_ctl_bundle_t           out_ctl;
  logic [$clog2(DEPTH):0]  out_count;

  modport slave (
    input  in_flush, in_valid, in_insnbits, in_op, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_pc, out_imm, out_src1, out_src2,
           out_dst, out_src1_v, out_src2_v, out_dst_v, out_alu_op, out_ctl,
           out_count
  );

  modport master (
    output in_flush, in_valid, in_insnbits, in_op, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_pc, out_imm, out_src1, out_src2,
           out_dst, out_src1_v, out_src2_v, out_dst_v, out_alu_op, out_ctl,
           out_count
  );

endinterface

// File: rtl/decode_queue_decode_fields.sv
// Combinational decode of one fetched instruction into a decoded_insn_t.
module decode_fields import decode_queue_pkg::*; (
  input  logic [31:0]        insnbits,
  input  opcode_t            op,
  input  logic [DQ_XLEN-1:0] pc,
  output decoded_insn_t      dec
);

  function automatic logic [DQ_XLEN-1:0] sext(input logic [25:0] f, input int w);
    logic signed [DQ_XLEN-1:0] r;
    r = signed'(DQ_XLEN'(f) << (DQ_XLEN - w));
    return r >>> (DQ_XLEN - w);
  endfunction

  // No immediate or register field lives in these bits.
  logic unused_bits;
  assign unused_bits = ^{insnbits[31], insnbits[28:26]};

  always_comb begin
    dec        = '0;
    dec.op     = op;
    dec.pc     = pc;

    dec.dst    = insnbits[4:0];
    dec.dst_v  = 1'b1;
    case (op)
      OP_B, OP_BR, OP_B_COND, OP_BLR, OP_RET, OP_NOP, OP_HLT,
      OP_CBZ, OP_CBNZ, OP_STUR, OP_CMP, OP_TST: dec.dst_v = 1'b0;
      OP_BL:   dec.dst = GPR_IDX_SIZE'(30);
      default: ;
    endcase

    dec.src1   = insnbits[9:5];
    dec.src1_v = 1'b1;
    case (op)
      OP_MOVZ, OP_ADR, OP_ADRP, OP_B, OP_B_COND, OP_BL, OP_NOP,
      OP_HLT:                  dec.src1_v = 1'b0;
      OP_CBZ, OP_CBNZ, OP_MOVK: dec.src1  = insnbits[4:0];
      default: ;
    endcase

    if (op == OP_STUR) begin
      dec.src2   = insnbits[4:0];
      dec.src2_v = 1'b1;
    end else if (reads_rm(op)) begin
      dec.src2   = insnbits[20:16];
      dec.src2_v = 1'b1;
    end

    case (op)
      OP_LDUR, OP_STUR:           dec.imm = sext(26'(insnbits[20:12]), 9);
      OP_ADD, OP_SUB, OP_UBFM,
      OP_ASR:                     dec.imm = DQ_XLEN'(insnbits[21:10]);
      OP_MOVK, OP_MOVZ:           dec.imm = DQ_XLEN'(insnbits[20:5]) << {insnbits[22:21], 4'b0000};
      OP_ADRP:                    dec.imm = sext(26'({insnbits[23:5], insnbits[30:29]}), 21) << 12;
      OP_ADR:                     dec.imm = sext(26'({insnbits[23:5], insnbits[30:29]}), 21);
      OP_B, OP_BL:                dec.imm = sext(insnbits[25:0], 26) << 2;
      OP_B_COND, OP_CBZ, OP_CBNZ: dec.imm = sext(26'(insnbits[23:5]), 19) << 2;
      default:                    dec.imm = '0;
    endcase

    case (op)
      OP_SUB, OP_SUBS, OP_CMP: dec.alu_op = ALU_OP_MINUS;
      OP_MVN:                  dec.alu_op = ALU_OP_ORN;
      OP_ORR:                  dec.alu_op = ALU_OP_OR;
      OP_EOR:                  dec.alu_op = ALU_OP_EOR;
      OP_ANDS, OP_TST:         dec.alu_op = ALU_OP_AND;
      OP_UBFM:                 dec.alu_op = ALU_OP_UBFM;
      OP_SBFM:                 dec.alu_op = ALU_OP_SBFM;
      OP_MOVK, OP_MOVZ:        dec.alu_op = ALU_OP_MOV;
      OP_CSEL:                 dec.alu_op = ALU_OP_CSEL;
      OP_CSINC:                dec.alu_op = ALU_OP_CSINC;
      OP_CSINV:                dec.alu_op = ALU_OP_CSINV;
      default:                 dec.alu_op = ALU_OP_PLUS;
    endcase

    dec.ctl.valb_sel   = reads_rm(op);
    dec.ctl.set_CC     = op inside {OP_ADDS, OP_ANDS, OP_SUBS, OP_CMP, OP_TST};
    dec.ctl.dmem_read  = (op == OP_LDUR);
    dec.ctl.wval_sel   = (op == OP_LDUR);
    dec.ctl.dmem_write = (op == OP_STUR);
    dec.ctl.w_enable   = dec.dst_v;
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry instruction buffer; decodes on enqueue and
// presents the buffered head to rename/dispatch.
module decode_queue import decode_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN  = DQ_XLEN
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  decoded_insn_t    dec_p0;
  decoded_insn_t    mem [DEPTH];
  decoded_insn_t    head_p1;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Stage p0: decode straight off the fetch inputs
  decode_fields u_decode_fields (
    .insnbits (bus.in_insnbits),
    .op       (bus.in_op),
    .pc       (DQ_XLEN'(bus.in_pc)),
    .dec      (dec_p0)
  );

  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid  && bus.in_ready  && !bus.in_flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.in_flush;

  // Stage p1: buffer storage; reset also scrubs stale entries
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.in_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_p0;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_p1        = mem[rd_ptr];
  assign bus.out_op     = head_p1.op;
  assign bus.out_pc     = XLEN'(head_p1.pc);
  assign bus.out_imm    = XLEN'(head_p1.imm);
  assign bus.out_src1   = head_p1.src1;
  assign bus.out_src2   = head_p1.src2;
  assign bus.out_dst    = head_p1.dst;
  assign bus.out_src1_v = head_p1.src1_v;
  assign bus.out_src2_v = head_p1.src2_v;
  assign bus.out_dst_v  = head_p1.dst_v;
  assign bus.out_alu_op = head_p1.alu_op;
  assign bus.out_ctl    = head_p1.ctl;
  assign bus.out_count  = count;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed test-plan vectors plus random traffic.
module tb_decode_queue;
  import decode_queue_pkg::*;

  typedef struct packed {
    opcode_t       op;
    logic [63:0]   pc;
    logic [63:0]   imm;
    logic [4:0]    src1;
    logic          src1_v;
    logic [4:0]    src2;
    logic          src2_v;
    logic [4:0]    dst;
    logic          dst_v;
    alu_op_t       alu;
    d_ctl_bundle_t ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  decode_queue_if #(.XLEN(64), .DEPTH(4)) bus ();

  decode_queue #(.DEPTH(4), .XLEN(64)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Sign extension by arithmetic: flip the sign bit, then subtract its weight.
  function automatic logic [63:0] sx(input logic [63:0] v, input int n);
    logic [63:0] m;
    m = 64'd1 << (n - 1);
    v = v & ((m << 1) - 64'd1);
    return (v ^ m) - m;
  endfunction

  function automatic exp_t model(input logic [31:0] i, input opcode_t op, input logic [63:0] pc);
    exp_t e;
    logic rm;
    e = '0;
    e.op = op;
    e.pc = pc;
    rm = op inside {OP_ADDS, OP_SUBS, OP_CMP, OP_MVN, OP_ORR, OP_EOR, OP_ANDS,
                    OP_TST, OP_CSEL, OP_CSINC, OP_CSINV, OP_CSNEG};
    e.dst_v  = !(op inside {OP_B, OP_BR, OP_B_COND, OP_BLR, OP_RET, OP_NOP, OP_HLT,
                            OP_CBZ, OP_CBNZ, OP_STUR, OP_CMP, OP_TST});
    e.dst    = (op == OP_BL) ? 5'd30 : i[4:0];
    e.src1_v = !(op inside {OP_MOVZ, OP_ADR, OP_ADRP, OP_B, OP_B_COND, OP_BL, OP_NOP, OP_HLT});
    e.src1   = (op inside {OP_CBZ, OP_CBNZ, OP_MOVK}) ? i[4:0] : i[9:5];
    if (op == OP_STUR) begin e.src2 = i[4:0];   e.src2_v = 1'b1; end
    else if (rm)       begin e.src2 = i[20:16]; e.src2_v = 1'b1; end
    if (op inside {OP_LDUR, OP_STUR})                 e.imm = sx(64'(i[20:12]), 9);
    else if (op inside {OP_ADD, OP_SUB, OP_UBFM, OP_ASR}) e.imm = 64'(i[21:10]);
    else if (op inside {OP_MOVK, OP_MOVZ})            e.imm = 64'(i[20:5]) * (64'd1 << (16 * int'(i[22:21])));
    else if (op == OP_ADRP)                           e.imm = sx(64'({i[23:5], i[30:29]}), 21) * 64'd4096;
    else if (op == OP_ADR)                            e.imm = sx(64'({i[23:5], i[30:29]}), 21);
    else if (op inside {OP_B, OP_BL})                 e.imm = sx(64'(i[25:0]), 26) * 64'd4;
    else if (op inside {OP_B_COND, OP_CBZ, OP_CBNZ})  e.imm = sx(64'(i[23:5]), 19) * 64'd4;
    case (op)
      OP_SUB, OP_SUBS, OP_CMP: e.alu = ALU_OP_MINUS;
      OP_MVN:                  e.alu = ALU_OP_ORN;
      OP_ORR:                  e.alu = ALU_OP_OR;
      OP_EOR:                  e.alu = ALU_OP_EOR;
      OP_ANDS, OP_TST:         e.alu = ALU_OP_AND;
      OP_UBFM:                 e.alu = ALU_OP_UBFM;
      OP_SBFM:                 e.alu = ALU_OP_SBFM;
      OP_MOVK, OP_MOVZ:        e.alu = ALU_OP_MOV;
      OP_CSEL:                 e.alu = ALU_OP_CSEL;
      OP_CSINC:                e.alu = ALU_OP_CSINC;
      OP_CSINV:                e.alu = ALU_OP_CSINV;
      default:                 e.alu = ALU_OP_PLUS;
    endcase
    e.ctl.valb_sel   = rm;
    e.ctl.set_CC     = op inside {OP_ADDS, OP_ANDS, OP_SUBS, OP_CMP, OP_TST};
    e.ctl.dmem_read  = (op == OP_LDUR);
    e.ctl.wval_sel   = (op == OP_LDUR);
    e.ctl.dmem_write = (op == OP_STUR);
    e.ctl.w_enable   = e.dst_v;
    return e;
  endfunction

  function automatic exp_t mk(input opcode_t op, input logic [63:0] pc, input logic [63:0] imm,
                              input logic [4:0] s1, input logic s1v, input logic [4:0] s2,
                              input logic s2v, input logic [4:0] d, input logic dv,
                              input alu_op_t alu, input logic [5:0] ctl);
    exp_t e;
    e.op = op; e.pc = pc; e.imm = imm;
    e.src1 = s1; e.src1_v = s1v; e.src2 = s2; e.src2_v = s2v;
    e.dst = d; e.dst_v = dv; e.alu = alu; e.ctl = d_ctl_bundle_t'(ctl);
    return e;
  endfunction

  // Drive one cycle; the expected entry is committed at the edge that takes it.
  task automatic step(input logic v, input logic [31:0] insn, input opcode_t op,
                      input logic [63:0] pc, input exp_t e, input logic fl,
                      input logic ordy, output logic acc);
    bus.in_valid = v; bus.in_insnbits = insn; bus.in_op = op; bus.in_pc = pc;
    bus.in_flush = fl; bus.out_ready = ordy;
    #1;
    acc = v && bus.in_ready && !fl;
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, 32'd0, OP_NOP, 64'd0, '0, 1'b0, ordy, a);
  endtask

  task automatic rnd_push(input logic ordy, output logic acc);
    logic [31:0] insn;
    opcode_t op;
    logic [63:0] pc;
    insn = $urandom;
    op   = opcode_t'($urandom_range(0, int'(OP_ERROR)));
    pc   = {$urandom, $urandom};
    step(1'b1, insn, op, pc, model(insn, op, pc), 1'b0, ordy, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin idle(1'b1); n++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_flush = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd1);
    chk({tag, "_count"},     64'(bus.out_count), 64'd0);
    chk({tag, "_imm"},       bus.out_imm, 64'd0);
    chk({tag, "_pc"},        bus.out_pc, 64'd0);
    chk({tag, "_regs"},      64'({bus.out_src1, bus.out_src2, bus.out_dst,
                                  bus.out_src1_v, bus.out_src2_v, bus.out_dst_v}), 64'd0);
    chk({tag, "_op_alu_ctl"}, 64'({bus.out_op, bus.out_alu_op, bus.out_ctl}), 64'd0);
  endtask

  // Monitor: occupancy and head contents against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 64'(bus.out_count), 64'(exp_q.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 4));
      if (bus.out_valid && exp_q.size() != 0) begin
        chk("head_op", 64'(bus.out_op), 64'(exp_q[0].op));
        chk("head_pc", bus.out_pc, exp_q[0].pc);
        chk("head_imm", bus.out_imm, exp_q[0].imm);
        chk("head_src1_v", 64'(bus.out_src1_v), 64'(exp_q[0].src1_v));
        if (exp_q[0].src1_v) chk("head_src1", 64'(bus.out_src1), 64'(exp_q[0].src1));
        chk("head_src2_v", 64'(bus.out_src2_v), 64'(exp_q[0].src2_v));
        if (exp_q[0].src2_v) chk("head_src2", 64'(bus.out_src2), 64'(exp_q[0].src2));
        chk("head_dst_v", 64'(bus.out_dst_v), 64'(exp_q[0].dst_v));
        if (exp_q[0].dst_v) chk("head_dst", 64'(bus.out_dst), 64'(exp_q[0].dst));
        chk("head_alu_op", 64'(bus.out_alu_op), 64'(exp_q[0].alu));
        chk("head_ctl", 64'(bus.out_ctl), 64'(exp_q[0].ctl));
        if (bus.out_ready && !bus.in_flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    bus.in_valid = 1'b0; bus.in_flush = 1'b0; bus.out_ready = 1'b0;
    bus.in_insnbits = '0; bus.in_op = OP_NOP; bus.in_pc = '0;

    do_reset();
    chk_reset_outputs("reset");

    // Directed decode vectors
    step(1'b1, 32'h91001423, OP_ADD, 64'h1000,
         mk(OP_ADD, 64'h1000, 64'd5, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, ALU_OP_PLUS, 6'b000001),
         1'b0, 1'b1, acc);
    chk("add_accept", 64'(acc), 64'd1);
    step(1'b1, 32'hF85F8082, OP_LDUR, 64'h1004,
         mk(OP_LDUR, 64'h1004, 64'hFFFF_FFFF_FFFF_FFF8, 5'd4, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1,
            ALU_OP_PLUS, 6'b001011), 1'b0, 1'b1, acc);
    step(1'b1, 32'h94000004, OP_BL, 64'h1008,
         mk(OP_BL, 64'h1008, 64'd16, 5'd0, 1'b0, 5'd0, 1'b0, 5'd30, 1'b1, ALU_OP_PLUS, 6'b000001),
         1'b0, 1'b1, acc);
    step(1'b1, 32'hB4000047, OP_CBZ, 64'h100C,
         mk(OP_CBZ, 64'h100C, 64'd8, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, ALU_OP_PLUS, 6'b000000),
         1'b0, 1'b1, acc);
    drain();

    // Fill to full with the consumer stalled, then release it for one cycle
    for (int k = 0; k < 4; k++) begin
      rnd_push(1'b0, acc);
      chk("fill_accept", 64'(acc), 64'd1);
    end
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_count", 64'(bus.out_count), 64'd4);
    begin
      logic [31:0] insn5;
      exp_t e5;
      insn5 = 32'h8B020020;
      e5 = model(insn5, OP_ADDS, 64'h2000);
      step(1'b1, insn5, OP_ADDS, 64'h2000, e5, 1'b0, 1'b1, acc);
      chk("full_no_passthrough", 64'(acc), 64'd0);
      step(1'b1, insn5, OP_ADDS, 64'h2000, e5, 1'b0, 1'b0, acc);
      chk("accept_after_pop", 64'(acc), 64'd1);
    end
    drain();

    // Flush with a same-cycle push and pop
    for (int k = 0; k < 3; k++) rnd_push(1'b0, acc);
    step(1'b1, 32'h91000421, OP_ADD, 64'h3000, model(32'h91000421, OP_ADD, 64'h3000),
         1'b1, 1'b1, acc);
    chk("flush_count", 64'(bus.out_count), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    step(1'b1, 32'hD2800545, OP_MOVZ, 64'h3004, model(32'hD2800545, OP_MOVZ, 64'h3004),
         1'b0, 1'b0, acc);
    chk("post_flush_count", 64'(bus.out_count), 64'd1);
    drain();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      logic v, ordy, fl;
      logic [31:0] insn;
      opcode_t op;
      logic [63:0] pc;
      v    = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      fl   = ($urandom % 25) == 0;
      insn = $urandom;
      op   = opcode_t'($urandom_range(0, int'(OP_ERROR)));
      pc   = {$urandom, $urandom};
      step(v, insn, op, pc, model(insn, op, pc), fl, ordy, acc);
    end
    drain();

    // Reset with live entries must scrub the stored data
    for (int k = 0; k < 2; k++) rnd_push(1'b0, acc);
    do_reset();
    chk_reset_outputs("rerst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
